// File: rtl/cocktail_pkg.sv
// Shared encodings for the cocktail machine: order states, key codes and the recipe ROM.
// The screen block imports the same state encodings.
package cocktail_pkg;

  typedef enum logic [1:0] {
    ST_MENU   = 2'b00,
    ST_CUSTOM = 2'b01,
    ST_POUR   = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  localparam int unsigned NUM_PUMPS = 4;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;
  localparam logic [3:0] KEY_CUSTOM = 4'hC;

  // Pour units for a drink on one pump; drink 0 and 7 are empty.
  function automatic logic [3:0] recipe(input logic [2:0] drink, input logic [1:0] pump);
    logic [15:0] row;  // {pump3, pump2, pump1, pump0}
    case (drink)
      3'd1:    row = {4'd0, 4'd0, 4'd1, 4'd2};
      3'd2:    row = {4'd0, 4'd1, 4'd3, 4'd0};
      3'd3:    row = {4'd1, 4'd1, 4'd1, 4'd1};
      3'd4:    row = {4'd2, 4'd0, 4'd0, 4'd4};
      3'd5:    row = {4'd3, 4'd3, 4'd0, 4'd0};
      3'd6:    row = {4'd0, 4'd2, 4'd2, 4'd2};
      default: row = 16'd0;
    endcase
    return row[{pump, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/pour_timer.sv
// Pour prescaler plus four saturating 4-bit unit counters driving the pump enables.
// ORDER_CTRL_SEQ_POUR_EN selects sequential (lowest pump first) instead of parallel pour.
module pour_timer
  import cocktail_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_run,
  input  logic        i_pour_next,
  input  logic        i_load,
  input  logic [15:0] i_load_units,
  input  logic        i_clear,
  input  logic        i_inc,
  input  logic [1:0]  i_inc_sel,
  output logic [3:0]  o_pump_en,
  output logic        o_all_zero
);

  localparam int unsigned PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  logic [PW-1:0]   r_presc;
  logic [3:0][3:0] r_units;
  logic [3:0][3:0] w_units_d;
  logic [3:0]      r_pump_en;
  logic [3:0]      w_active;
  logic            w_tick;

  // Pumps that are both enabled and decremented for a given set of counters.
  function automatic logic [3:0] active_mask(input logic [3:0][3:0] u);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef ORDER_CTRL_SEQ_POUR_EN
      if (u[i] != 4'd0 && m == 4'd0) m[i] = 1'b1;
`else
      m[i] = (u[i] != 4'd0);
`endif
    end
    return m;
  endfunction

  assign w_active   = active_mask(r_units);
  assign w_tick     = i_run && (r_presc == PW'(UNIT_CYCLES - 1));
  assign o_all_zero = (r_units == '0);
  assign o_pump_en  = r_pump_en;

  // Clear outranks a coincident tick, so a cancelled pour never decrements.
  always_comb begin
    w_units_d = r_units;
    if (i_clear) begin
      w_units_d = '0;
    end else if (i_load) begin
      w_units_d = i_load_units;
    end else if (i_inc) begin
      if (r_units[i_inc_sel] != 4'hF) w_units_d[i_inc_sel] = r_units[i_inc_sel] + 4'd1;
    end else if (w_tick) begin
      for (int i = 0; i < 4; i++) begin
        if (w_active[i]) w_units_d[i] = r_units[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_units   <= '0;
      r_pump_en <= '0;
    end else begin
      r_units <= w_units_d;
      if (!i_run || w_tick) r_presc <= '0;
      else                  r_presc <= r_presc + 1'b1;
      r_pump_en <= i_pour_next ? active_mask(w_units_d) : 4'd0;
    end
  end

endmodule

// File: rtl/order_controller.sv
// Keypad order FSM feeding the screen block and the four dispensing pumps.
// Define ORDER_CTRL_SEQ_POUR_EN for sequential pour (handled inside pour_timer).
module order_controller
  import cocktail_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned DONE_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] state,
  output logic [2:0] drink,
  output logic [3:0] pump_en,
  output logic       busy
);

  localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_e        r_state, w_state_d;
  logic [2:0]    r_drink, w_drink_d;
  logic          r_busy;
  logic [DW-1:0] r_done_cnt;

  logic          w_load, w_clear, w_inc, w_all_zero;
  logic [1:0]    w_inc_sel;
  logic [15:0]   w_load_units;
  logic          w_is_drink, w_is_pump, w_done_end;

  assign w_is_drink = key_code >= 4'd1 && key_code <= 4'd6;
  assign w_is_pump  = key_code >= 4'd1 && key_code <= 4'd4;
  assign w_inc_sel  = key_code[1:0] - 2'd1;
  assign w_done_end = (r_done_cnt == DW'(DONE_CYCLES - 1));

  always_comb begin
    for (int p = 0; p < 4; p++) w_load_units[p*4 +: 4] = recipe(r_drink, 2'(p));
  end

  always_comb begin
    w_state_d = r_state;
    w_drink_d = r_drink;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    w_inc     = 1'b0;
    unique case (r_state)
      ST_MENU: begin
        if (key_valid) begin
          if (w_is_drink) begin
            w_drink_d = key_code[2:0];
          end else if (key_code == KEY_ENTER && r_drink != 3'd0) begin
            w_load    = 1'b1;
            w_state_d = ST_POUR;
          end else if (key_code == KEY_CUSTOM) begin
            w_clear   = 1'b1;
            w_drink_d = 3'd0;
            w_state_d = ST_CUSTOM;
          end else if (key_code == KEY_CANCEL) begin
            w_drink_d = 3'd0;
          end
        end
      end
      ST_CUSTOM: begin
        if (key_valid) begin
          if (w_is_pump) begin
            w_inc = 1'b1;
          end else if (key_code == KEY_ENTER && !w_all_zero) begin
            w_state_d = ST_POUR;
          end else if (key_code == KEY_CANCEL) begin
            w_clear   = 1'b1;
            w_state_d = ST_MENU;
          end
        end
      end
      ST_POUR: begin
        if (key_valid && key_code == KEY_CANCEL) begin
          w_clear   = 1'b1;
          w_drink_d = 3'd0;
          w_state_d = ST_MENU;
        end else if (w_all_zero) begin
          w_state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_done_end) begin
          w_drink_d = 3'd0;
          w_state_d = ST_MENU;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_MENU;
      r_drink    <= 3'd0;
      r_busy     <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      r_drink <= w_drink_d;
      r_busy  <= (w_state_d == ST_POUR) || (w_state_d == ST_DONE);
      if (r_state == ST_DONE && !w_done_end) r_done_cnt <= r_done_cnt + 1'b1;
      else                                   r_done_cnt <= '0;
    end
  end

  pour_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_pour_timer (
    .clk         (clk),
    .rst         (rst),
    .i_run       (r_state == ST_POUR),
    .i_pour_next (w_state_d == ST_POUR),
    .i_load      (w_load),
    .i_load_units(w_load_units),
    .i_clear     (w_clear),
    .i_inc       (w_inc),
    .i_inc_sel   (w_inc_sel),
    .o_pump_en   (pump_en),
    .o_all_zero  (w_all_zero)
  );

  assign state = r_state;
  assign drink = r_drink;
  assign busy  = r_busy;

endmodule

// File: tb/tb_order_controller.sv
// Bench for order_controller: timeline model of the order flow plus directed literal checks.
module tb_order_controller;

  localparam int U = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] state;
  logic [2:0] drink;
  logic [3:0] pump_en;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  order_controller #(
    .UNIT_CYCLES(U),
    .DONE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .state    (state),
    .drink    (drink),
    .pump_en  (pump_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: order mode, selected drink, custom units, and the pour plan plus elapsed cycles.
  int rec[7][4] = '{'{0, 0, 0, 0}, '{2, 1, 0, 0}, '{0, 3, 1, 0}, '{1, 1, 1, 1},
                    '{4, 0, 0, 2}, '{0, 0, 3, 3}, '{2, 2, 2, 0}};
  int m_state = 0, m_drink = 0, m_k = 0, m_dk = 0;
  int m_units[4] = '{0, 0, 0, 0};
  int m_plan[4]  = '{0, 0, 0, 0};

  function automatic int pour_len();
    int t = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef ORDER_CTRL_SEQ_POUR_EN
      t += m_plan[i] * U;
`else
      if (m_plan[i] * U > t) t = m_plan[i] * U;
`endif
    end
    return t;
  endfunction

  function automatic int exp_pump();
    int r = 0, start = 0;
    if (m_state != 2) return 0;
    for (int i = 0; i < 4; i++) begin
`ifdef ORDER_CTRL_SEQ_POUR_EN
      if (m_k >= start && m_k < start + m_plan[i] * U) r |= (1 << i);
      start += m_plan[i] * U;
`else
      if (m_k < m_plan[i] * U) r |= (1 << i);
`endif
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_drink = 0; m_k = 0; m_dk = 0;
      for (int i = 0; i < 4; i++) m_units[i] = 0;
    end else begin
      case (m_state)
        0: if (key_valid) begin
          if (key_code >= 1 && key_code <= 6) m_drink = int'(key_code);
          else if (key_code == 4'hA && m_drink != 0) begin
            for (int i = 0; i < 4; i++) m_plan[i] = rec[m_drink][i];
            m_k = 0; m_state = 2;
          end else if (key_code == 4'hC) begin
            for (int i = 0; i < 4; i++) m_units[i] = 0;
            m_drink = 0; m_state = 1;
          end else if (key_code == 4'hB) m_drink = 0;
        end
        1: if (key_valid) begin
          if (key_code >= 1 && key_code <= 4) begin
            if (m_units[key_code - 1] < 15) m_units[key_code - 1]++;
          end else if (key_code == 4'hA &&
                       (m_units[0] + m_units[1] + m_units[2] + m_units[3]) != 0) begin
            for (int i = 0; i < 4; i++) m_plan[i] = m_units[i];
            m_k = 0; m_state = 2;
          end else if (key_code == 4'hB) begin
            for (int i = 0; i < 4; i++) m_units[i] = 0;
            m_state = 0;
          end
        end
        2: if (key_valid && key_code == 4'hB) begin
          m_state = 0; m_drink = 0;
        end else if (m_k == pour_len()) begin
          m_state = 3; m_dk = 0;
        end else m_k++;
        default: if (m_dk == D - 1) begin
          m_state = 0; m_drink = 0;
        end else m_dk++;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("state", int'(state), m_state);
    chk("drink", int'(drink), m_drink);
    chk("pump_en", int'(pump_en), exp_pump());
    chk("busy", int'(busy), (m_state >= 2) ? 1 : 0);
  end

  task automatic press(input int code);
    key_valid = 1'b1;
    key_code  = 4'(code);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  initial begin
    int c0, c1, c3, first_done, done_len;
    int seen[20];
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_pump", int'(pump_en), 0);
    chk("rst_busy", int'(busy), 0);

    // Menu selection and cancel
    press(3); chk("key3_drink", int'(drink), 3); chk("key3_state", int'(state), 0);
    press(5); chk("key5_drink", int'(drink), 5);
    press(11); chk("cancel_drink", int'(drink), 0);
    press(10); chk("enter_nodrink", int'(state), 0);

    // Drink 4: pump0 16 cycles, pump3 8 cycles
    press(4); press(10);
    chk("d4_state", int'(state), 2);
`ifdef ORDER_CTRL_SEQ_POUR_EN
    chk("d4_pump", int'(pump_en), 1);
`else
    chk("d4_pump", int'(pump_en), 9);
`endif
    c0 = 0; c3 = 0; first_done = -1; done_len = 0;
    for (int k = 0; k < 40; k++) begin
      if (pump_en[0]) c0++;
      if (pump_en[3]) c3++;
      if (state == 2'b11) begin
        if (first_done < 0) first_done = k;
        done_len++;
      end
      @(negedge clk);
    end
    chk("d4_pump3_len", c3, 8);
    chk("d4_pump0_len", c0, 16);
`ifdef ORDER_CTRL_SEQ_POUR_EN
    chk("d4_done_at", first_done, 25);
`else
    chk("d4_done_at", first_done, 17);
`endif
    chk("d4_done_len", done_len, 8);
    chk("d4_menu", int'(state), 0);
    chk("d4_drink0", int'(drink), 0);

    // Custom: empty ENTER ignored, pump1 saturates at 15 units
    press(12); chk("custom_state", int'(state), 1);
    press(10); chk("custom_empty_enter", int'(state), 1);
    for (int i = 0; i < 17; i++) press(2);
    press(10);
    c1 = 0;
    for (int k = 0; k < 80; k++) begin
      if (pump_en[1]) c1++;
      @(negedge clk);
    end
    chk("custom_sat_len", c1, 60);
    chk("custom_menu", int'(state), 0);

    // Custom mix on pumps 0 and 2
    press(12); press(1); press(3); press(3); press(10);
    repeat (30) @(negedge clk);

    // Drink 6, CANCEL landing on a tick edge
    press(6); press(10);
    repeat (3) @(negedge clk);
    press(11);
    chk("cancel_pump", int'(pump_en), 0);
    chk("cancel_state", int'(state), 0);
    chk("cancel_drink", int'(drink), 0);

    // Asynchronous reset mid-pour
    press(6); press(10);
    repeat (2) @(negedge clk);
`ifdef ORDER_CTRL_SEQ_POUR_EN
    chk("pre_rst_pump", int'(pump_en), 1);
`else
    chk("pre_rst_pump", int'(pump_en), 7);
`endif
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_pump", int'(pump_en), 0);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_drink", int'(drink), 0);
    chk("async_rst_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;

    // Drink 3: all four pumps one unit each
    press(3); press(10);
    for (int k = 0; k < 20; k++) begin
      seen[k] = int'(pump_en);
      @(negedge clk);
    end
`ifdef ORDER_CTRL_SEQ_POUR_EN
    chk("seq_p0", seen[0], 1);
    chk("seq_p1", seen[4], 2);
    chk("seq_p2", seen[8], 4);
    chk("seq_p3", seen[12], 8);
    chk("seq_p3_end", seen[15], 8);
    chk("seq_gap", seen[16], 0);
`else
    chk("par_p", seen[0], 15);
    chk("par_p_end", seen[3], 15);
    chk("par_gap", seen[4], 0);
`endif
    repeat (20) @(negedge clk);
    chk("final_state", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
